// File: rtl/axi_host_arbiter.sv
// Shares one AXI device port between NumHosts hosts: round-robin AW/AR arbitration,
// W steering from a FIFO of granted AW hosts, and B/R routing by the host index prefixed onto the ID.

module axi_host_arbiter_chan #(
  parameter int NumHosts     = 2,
  parameter int IdWidth      = 1,
  parameter int PayloadWidth = 8,
  localparam int HostIdxWidth = $clog2(NumHosts),
  localparam int DevIdWidth   = IdWidth + HostIdxWidth
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NumHosts-1:0]              req_valid,
  input  logic [NumHosts*PayloadWidth-1:0] req_payload,
  input  logic [NumHosts*IdWidth-1:0]      req_id,
  input  logic                             stall,
  output logic [NumHosts-1:0]              req_ready,
  output logic                             dev_valid,
  output logic [PayloadWidth-1:0]          dev_payload,
  output logic [DevIdWidth-1:0]            dev_id,
  input  logic                             dev_ready
);
  logic [HostIdxWidth-1:0] ptr_q, offset, winner, next_ptr;
  logic [HostIdxWidth:0]   win_sum, nxt_sum;
  logic [NumHosts-1:0]     rot;
  logic                    found, grant_fire, slot_full_q;
  logic [PayloadWidth-1:0] payload_q;
  logic [DevIdWidth-1:0]   id_q;

  // Rotate the valids so bit 0 is the pointer position; the lowest set bit is the winner.
  always_comb begin
    rot     = NumHosts'({req_valid, req_valid} >> ptr_q);
    found   = 1'b0;
    offset  = '0;
    for (int k = NumHosts - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found  = 1'b1;
        offset = HostIdxWidth'(k);
      end
    end
    win_sum = {1'b0, ptr_q} + {1'b0, offset};
    if (win_sum >= (HostIdxWidth+1)'(NumHosts)) win_sum = win_sum - (HostIdxWidth+1)'(NumHosts);
    winner  = win_sum[HostIdxWidth-1:0];
    nxt_sum = {1'b0, winner} + 1'b1;
    if (nxt_sum == (HostIdxWidth+1)'(NumHosts)) nxt_sum = '0;
    next_ptr = nxt_sum[HostIdxWidth-1:0];
    req_ready = '0;
    if (rst_ni && !slot_full_q && !stall && found) req_ready[winner] = 1'b1;
  end

  assign grant_fire  = |(req_valid & req_ready);
  assign dev_valid   = slot_full_q;
  assign dev_payload = payload_q;
  assign dev_id      = id_q;

  // Grant needs an empty slot and drain needs a full one, so they never coincide.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q       <= '0;
      slot_full_q <= 1'b0;
      payload_q   <= '0;
      id_q        <= '0;
    end else if (grant_fire) begin
      ptr_q       <= next_ptr;
      slot_full_q <= 1'b1;
      payload_q   <= req_payload[winner*PayloadWidth +: PayloadWidth];
      id_q        <= {winner, req_id[winner*IdWidth +: IdWidth]};
    end else if (slot_full_q && dev_ready) begin
      slot_full_q <= 1'b0;
    end
  end
endmodule

module axi_host_arbiter #(
  parameter int DataWidth  = 64,
  parameter int AddrWidth  = 56,
  parameter int IdWidth    = 1,
  parameter int NumHosts   = 2,
  parameter int WFifoDepth = 4,
  localparam int HostIdxWidth = $clog2(NumHosts),
  localparam int DevIdWidth   = IdWidth + HostIdxWidth,
  localparam int StrbWidth    = DataWidth / 8
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NumHosts-1:0]             host_aw_valid,
  output logic [NumHosts-1:0]             host_aw_ready,
  input  logic [NumHosts*IdWidth-1:0]     host_aw_id,
  input  logic [NumHosts*AddrWidth-1:0]   host_aw_addr,
  input  logic [NumHosts*8-1:0]           host_aw_len,
  input  logic [NumHosts*3-1:0]           host_aw_size,
  input  logic [NumHosts*2-1:0]           host_aw_burst,
  input  logic [NumHosts-1:0]             host_ar_valid,
  output logic [NumHosts-1:0]             host_ar_ready,
  input  logic [NumHosts*IdWidth-1:0]     host_ar_id,
  input  logic [NumHosts*AddrWidth-1:0]   host_ar_addr,
  input  logic [NumHosts*8-1:0]           host_ar_len,
  input  logic [NumHosts*3-1:0]           host_ar_size,
  input  logic [NumHosts*2-1:0]           host_ar_burst,
  input  logic [NumHosts-1:0]             host_w_valid,
  output logic [NumHosts-1:0]             host_w_ready,
  input  logic [NumHosts*DataWidth-1:0]   host_w_data,
  input  logic [NumHosts*StrbWidth-1:0]   host_w_strb,
  input  logic [NumHosts-1:0]             host_w_last,
  output logic [NumHosts-1:0]             host_b_valid,
  input  logic [NumHosts-1:0]             host_b_ready,
  output logic [NumHosts*IdWidth-1:0]     host_b_id,
  output logic [NumHosts*2-1:0]           host_b_resp,
  output logic [NumHosts-1:0]             host_r_valid,
  input  logic [NumHosts-1:0]             host_r_ready,
  output logic [NumHosts*IdWidth-1:0]     host_r_id,
  output logic [NumHosts*DataWidth-1:0]   host_r_data,
  output logic [NumHosts*2-1:0]           host_r_resp,
  output logic [NumHosts-1:0]             host_r_last,
  output logic                            device_aw_valid,
  input  logic                            device_aw_ready,
  output logic [DevIdWidth-1:0]           device_aw_id,
  output logic [AddrWidth-1:0]            device_aw_addr,
  output logic [7:0]                      device_aw_len,
  output logic [2:0]                      device_aw_size,
  output logic [1:0]                      device_aw_burst,
  output logic                            device_ar_valid,
  input  logic                            device_ar_ready,
  output logic [DevIdWidth-1:0]           device_ar_id,
  output logic [AddrWidth-1:0]            device_ar_addr,
  output logic [7:0]                      device_ar_len,
  output logic [2:0]                      device_ar_size,
  output logic [1:0]                      device_ar_burst,
  output logic                            device_w_valid,
  input  logic                            device_w_ready,
  output logic [DataWidth-1:0]            device_w_data,
  output logic [StrbWidth-1:0]            device_w_strb,
  output logic                            device_w_last,
  input  logic                            device_b_valid,
  output logic                            device_b_ready,
  input  logic [DevIdWidth-1:0]           device_b_id,
  input  logic [1:0]                      device_b_resp,
  input  logic                            device_r_valid,
  output logic                            device_r_ready,
  input  logic [DevIdWidth-1:0]           device_r_id,
  input  logic [DataWidth-1:0]            device_r_data,
  input  logic [1:0]                      device_r_resp,
  input  logic                            device_r_last
);
  // Valid/ready: a transfer happens on any clock edge where valid && ready; valid never waits on ready.
  localparam int ReqW = AddrWidth + 8 + 3 + 2;
  localparam int PtrW = $clog2(WFifoDepth);

  logic [NumHosts*ReqW-1:0] aw_payload, ar_payload;
  logic                     wfifo_full, wfifo_empty, aw_push, w_pop, w_head_valid;
  logic [HostIdxWidth-1:0]  aw_idx, w_head, b_host, r_host;
  logic [PtrW:0]            wr_q, rd_q, wfifo_count;
  logic [HostIdxWidth-1:0]  wfifo_mem [WFifoDepth];
  logic                     b_ok, r_ok;

  always_comb begin
    for (int i = 0; i < NumHosts; i++) begin
      aw_payload[i*ReqW +: ReqW] = {host_aw_addr[i*AddrWidth +: AddrWidth], host_aw_len[i*8 +: 8],
                                    host_aw_size[i*3 +: 3], host_aw_burst[i*2 +: 2]};
      ar_payload[i*ReqW +: ReqW] = {host_ar_addr[i*AddrWidth +: AddrWidth], host_ar_len[i*8 +: 8],
                                    host_ar_size[i*3 +: 3], host_ar_burst[i*2 +: 2]};
    end
  end

  axi_host_arbiter_chan #(.NumHosts(NumHosts), .IdWidth(IdWidth), .PayloadWidth(ReqW)) u_aw (
    .clk_i, .rst_ni,
    .req_valid(host_aw_valid), .req_payload(aw_payload), .req_id(host_aw_id),
    .stall(wfifo_full), .req_ready(host_aw_ready),
    .dev_valid(device_aw_valid),
    .dev_payload({device_aw_addr, device_aw_len, device_aw_size, device_aw_burst}),
    .dev_id(device_aw_id), .dev_ready(device_aw_ready)
  );

  axi_host_arbiter_chan #(.NumHosts(NumHosts), .IdWidth(IdWidth), .PayloadWidth(ReqW)) u_ar (
    .clk_i, .rst_ni,
    .req_valid(host_ar_valid), .req_payload(ar_payload), .req_id(host_ar_id),
    .stall(1'b0), .req_ready(host_ar_ready),
    .dev_valid(device_ar_valid),
    .dev_payload({device_ar_addr, device_ar_len, device_ar_size, device_ar_burst}),
    .dev_id(device_ar_id), .dev_ready(device_ar_ready)
  );

  always_comb begin
    aw_idx = '0;
    for (int i = 0; i < NumHosts; i++) if (host_aw_ready[i]) aw_idx = HostIdxWidth'(i);
  end
  assign aw_push = |(host_aw_valid & host_aw_ready);

  // The head bypasses the FIFO when it is empty, so W can follow its AW in the same cycle.
  assign wfifo_count  = wr_q - rd_q;
  assign wfifo_empty  = (wr_q == rd_q);
  assign wfifo_full   = (wfifo_count == (PtrW+1)'(WFifoDepth));
  assign w_head_valid = !wfifo_empty || aw_push;
  assign w_head       = wfifo_empty ? aw_idx : wfifo_mem[rd_q[PtrW-1:0]];
  assign w_pop        = device_w_valid && device_w_ready && device_w_last;

  always_comb begin
    host_w_ready   = '0;
    device_w_valid = 1'b0;
    device_w_data  = host_w_data[w_head*DataWidth +: DataWidth];
    device_w_strb  = host_w_strb[w_head*StrbWidth +: StrbWidth];
    device_w_last  = host_w_last[w_head];
    if (w_head_valid) begin
      host_w_ready[w_head] = device_w_ready;
      device_w_valid       = host_w_valid[w_head];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (aw_push) wr_q <= wr_q + 1'b1;
      if (w_pop)   rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (aw_push) wfifo_mem[wr_q[PtrW-1:0]] <= aw_idx;
  end

  // Responses carrying an out-of-range host index are swallowed so the device never stalls.
  assign b_host = device_b_id[DevIdWidth-1:IdWidth];
  assign r_host = device_r_id[DevIdWidth-1:IdWidth];
  assign b_ok   = {1'b0, b_host} < (HostIdxWidth+1)'(NumHosts);
  assign r_ok   = {1'b0, r_host} < (HostIdxWidth+1)'(NumHosts);

  always_comb begin
    host_b_valid   = '0;
    host_r_valid   = '0;
    device_b_ready = 1'b1;
    device_r_ready = 1'b1;
    if (b_ok) begin
      host_b_valid[b_host] = device_b_valid && rst_ni;
      device_b_ready       = host_b_ready[b_host];
    end
    if (r_ok) begin
      host_r_valid[r_host] = device_r_valid && rst_ni;
      device_r_ready       = host_r_ready[r_host];
    end
  end

  assign host_b_id   = {NumHosts{device_b_id[IdWidth-1:0]}};
  assign host_b_resp = {NumHosts{device_b_resp}};
  assign host_r_id   = {NumHosts{device_r_id[IdWidth-1:0]}};
  assign host_r_data = {NumHosts{device_r_data}};
  assign host_r_resp = {NumHosts{device_r_resp}};
  assign host_r_last = {NumHosts{device_r_last}};

  a_b_host_range: assert property (@(posedge clk_i) disable iff (!rst_ni) device_b_valid |-> b_ok);
  a_r_host_range: assert property (@(posedge clk_i) disable iff (!rst_ni) device_r_valid |-> r_ok);
endmodule
